// File: rtl/core_ctrl.sv
// Multi-cycle sequencer for the 16-bit core: fetch, decode, execute, memory and
// writeback, one instruction at a time, with bus timeout and illegal-opcode trap.
module core_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             run_i,
  output logic             imem_req_o,
  input  logic             imem_gnt_i,
  output logic             ir_we_o,
  input  logic [2:0]       opcode_i,
  input  logic             branch_taken_i,
  output logic             alu_src_imm_o,
  output logic             dmem_req_o,
  output logic             dmem_we_o,
  input  logic             dmem_ack_i,
  output logic             rf_we_o,
  output logic [1:0]       wb_sel_o,
  output logic             pc_we_o,
  output logic [1:0]       pc_sel_o,
  output logic             retire_o,
  output logic [CNT_W-1:0] retire_cnt_o,
  output logic             halt_o,
  output logic             illegal_o,
  output logic             bus_err_o,
  output logic [2:0]       state_o
);

  localparam int unsigned TmoW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  // Opcode encoding of IR[2:0]; 3'd7 is the only illegal value.
  localparam logic [2:0] ROp  = 3'd0;
  localparam logic [2:0] IOp  = 3'd1;
  localparam logic [2:0] LOp  = 3'd2;
  localparam logic [2:0] SOp  = 3'd3;
  localparam logic [2:0] BOp  = 3'd4;
  localparam logic [2:0] JOp  = 3'd5;
  localparam logic [2:0] JrOp = 3'd6;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StFault  = 3'd7
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       op_q;
  logic [TmoW-1:0]  tmo_q;
  logic [CNT_W-1:0] retire_cnt_q;
  logic             illegal_q, bus_err_q;
  logic             req_wait, tmo_hit;

  // A request is stalling when it is high this cycle without its gnt/ack.
  assign req_wait = ((state_q == StFetch) && !imem_gnt_i) ||
                    ((state_q == StMem) && !dmem_ack_i);
  assign tmo_hit  = (MEM_TIMEOUT != 0) && req_wait && (tmo_q == TmoW'(MEM_TIMEOUT));

  assign state_o      = state_q;
  assign retire_cnt_o = retire_cnt_q;
  assign illegal_o    = illegal_q;
  assign bus_err_o    = bus_err_q;

  // Next-state and Moore/handshake output decode.
  always_comb begin
    state_d       = state_q;
    imem_req_o    = 1'b0;
    ir_we_o       = 1'b0;
    alu_src_imm_o = 1'b0;
    dmem_req_o    = 1'b0;
    dmem_we_o     = 1'b0;
    rf_we_o       = 1'b0;
    wb_sel_o      = 2'd0;
    pc_we_o       = 1'b0;
    pc_sel_o      = 2'd0;
    retire_o      = 1'b0;
    halt_o        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (run_i) state_d = StFetch;
      end
      StFetch: begin
        imem_req_o = 1'b1;
        if (imem_gnt_i) begin
          ir_we_o = 1'b1;
          state_d = StDecode;
        end else if (tmo_hit) begin
          state_d = StFault;
        end
      end
      StDecode: begin
        state_d = (opcode_i == 3'd7) ? StFault : StExec;
      end
      StExec: begin
        alu_src_imm_o = (op_q == IOp) || (op_q == LOp) || (op_q == SOp) || (op_q == BOp);
        unique case (op_q)
          ROp, IOp: begin
            rf_we_o  = 1'b1;
            pc_we_o  = 1'b1;
            retire_o = 1'b1;
          end
          BOp: begin
            pc_we_o  = 1'b1;
            pc_sel_o = branch_taken_i ? 2'd1 : 2'd0;
            retire_o = 1'b1;
          end
          JOp, JrOp: begin
            rf_we_o  = 1'b1;
            wb_sel_o = 2'd2;
            pc_we_o  = 1'b1;
            pc_sel_o = (op_q == JOp) ? 2'd2 : 2'd3;
            retire_o = 1'b1;
          end
          LOp, SOp: state_d = StMem;
          default:  state_d = StFault;
        endcase
      end
      StMem: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = (op_q == SOp);
        if (dmem_ack_i) begin
          if (op_q == SOp) begin
            pc_we_o  = 1'b1;
            retire_o = 1'b1;
          end else begin
            state_d = StWb;
          end
        end else if (tmo_hit) begin
          state_d = StFault;
        end
      end
      StWb: begin
        rf_we_o  = 1'b1;
        wb_sel_o = 2'd1;
        pc_we_o  = 1'b1;
        retire_o = 1'b1;
      end
      StFault: begin
        halt_o = 1'b1;
      end
      default: state_d = StIdle;
    endcase
    if (retire_o) state_d = run_i ? StFetch : StIdle;
  end

  // State, latched opcode, timeout counter, retire counter and sticky fault causes.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      op_q         <= 3'd0;
      tmo_q        <= '0;
      retire_cnt_q <= '0;
      illegal_q    <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StDecode) op_q <= opcode_i;
      if ((state_d != state_q) && ((state_d == StFetch) || (state_d == StMem))) begin
        tmo_q <= '0;
      end else if (req_wait && (MEM_TIMEOUT != 0)) begin
        tmo_q <= tmo_q + TmoW'(1);
      end
      if (retire_o) retire_cnt_q <= retire_cnt_q + CNT_W'(1);
      if ((state_q == StDecode) && (state_d == StFault)) illegal_q <= 1'b1;
      if (tmo_hit) bus_err_q <= 1'b1;
    end
  end

endmodule
